// File: rtl/fifo_pkg.sv
// Shared constants and status bundle for the synchronous FWFT FIFO.
package fifo_pkg;

  localparam int FIFO_ADDR_WIDTH = 3;
  localparam int FIFO_DATA_WIDTH = 8;

  typedef struct packed {
    logic full;
    logic empty;
    logic almost_full;
    logic almost_empty;
    logic overflow;
    logic underflow;
  } fifo_status_t;

  localparam fifo_status_t FIFO_STATUS_RST = '{
    full:         1'b0,
    empty:        1'b1,
    almost_full:  1'b0,
    almost_empty: 1'b1,
    overflow:     1'b0,
    underflow:    1'b0
  };

endpackage

// File: rtl/fifo_ctrl.sv
// Pointer/flag controller for the FWFT FIFO register file.
// Latency: w_en combinational with the push; pointers, count and flags update at the same edge.
// Backpressure: push dropped when full unless a pop frees the head slot in the same cycle.
module fifo_ctrl
  import fifo_pkg::*;
#(
  parameter int ADDR_WIDTH = FIFO_ADDR_WIDTH,
  parameter int AF_LEVEL   = 2**ADDR_WIDTH - 1,
  parameter int AE_LEVEL   = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr,
  input  logic                  rd,
  input  logic                  clr_err,
  output logic                  w_en,
  output logic [ADDR_WIDTH-1:0] w_addr,
  output logic [ADDR_WIDTH-1:0] r_addr,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int CW = ADDR_WIDTH + 1;
  localparam logic [CW-1:0] CNT_FULL = CW'(2**ADDR_WIDTH);
  localparam logic [CW-1:0] CNT_AF   = CW'(AF_LEVEL);
  localparam logic [CW-1:0] CNT_AE   = CW'(AE_LEVEL);

  logic [ADDR_WIDTH-1:0] r_waddr;
  logic [ADDR_WIDTH-1:0] r_raddr;
  logic [CW-1:0]         r_count;
  fifo_status_t          r_status;

  logic                  w_push;
  logic                  w_pop;
  logic [CW-1:0]         w_count_nxt;
  fifo_status_t          w_status_nxt;

  // A push on full is legal when the head is popped in the same cycle.
  assign w_push = wr & (~r_status.full | rd);
  assign w_pop  = rd & ~r_status.empty;

  assign w_count_nxt = r_count + CW'(w_push) - CW'(w_pop);

  // Flags come from next-count so they change on the same edge as count.
  always_comb begin
    w_status_nxt              = r_status;
    w_status_nxt.full         = (w_count_nxt == CNT_FULL);
    w_status_nxt.empty        = (w_count_nxt == '0);
    w_status_nxt.almost_full  = (w_count_nxt >= CNT_AF);
    w_status_nxt.almost_empty = (w_count_nxt <= CNT_AE);
    w_status_nxt.overflow     = (wr & r_status.full & ~rd) | (r_status.overflow & ~clr_err);
    w_status_nxt.underflow    = (rd & r_status.empty) | (r_status.underflow & ~clr_err);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_waddr  <= '0;
      r_raddr  <= '0;
      r_count  <= '0;
      r_status <= FIFO_STATUS_RST;
    end else begin
      if (w_push) r_waddr <= r_waddr + 1'b1;
      if (w_pop)  r_raddr <= r_raddr + 1'b1;
      r_count  <= w_count_nxt;
      r_status <= w_status_nxt;
    end
  end

  assign w_en         = w_push;
  assign w_addr       = r_waddr;
  assign r_addr       = r_raddr;
  assign count        = r_count;
  assign full         = r_status.full;
  assign empty        = r_status.empty;
  assign almost_full  = r_status.almost_full;
  assign almost_empty = r_status.almost_empty;
  assign overflow     = r_status.overflow;
  assign underflow    = r_status.underflow;

endmodule
